// File: rtl/pc_pkg.sv
// Shared types and defaults for the fetch PC generator and its return-address stack.
package pc_pkg;

  typedef enum logic [2:0] {
    PC_SRC_RESET    = 3'd0,
    PC_SRC_SEQ      = 3'd1,
    PC_SRC_JUMP     = 3'd2,
    PC_SRC_RAS      = 3'd3,
    PC_SRC_REDIRECT = 3'd4,
    PC_SRC_TRAP     = 3'd5
  } pc_src_e;

  localparam int unsigned PC_INC_DEFAULT = 4;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: a push when full overwrites the oldest entry,
// and a simultaneous push+pop on a non-empty stack replaces the top in place.
module pc_ras
  import pc_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push,
  input  logic            pop,
  input  logic            clear,
  input  logic [XLEN-1:0] push_data,
  output logic [XLEN-1:0] top,
  output logic            empty,
  output logic            full
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;

  logic [XLEN-1:0] mem [RAS_DEPTH];
  logic [PW-1:0]   ptr;
  logic [CW-1:0]   count;
  logic            replace;
  logic            do_push;
  logic            do_pop;
  logic            wr_en;
  logic [PW-1:0]   wr_idx;

  assign empty   = (count == '0);
  assign full    = (count == CW'(RAS_DEPTH));
  assign top     = mem[ptr];

  // push+pop on an empty stack degrades to a plain push
  assign replace = push && pop && !empty && !clear;
  assign do_push = push && !replace && !clear;
  assign do_pop  = pop && !push && !empty && !clear;
  assign wr_en   = replace || do_push;
  assign wr_idx  = replace ? ptr : ptr + PW'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr   <= '0;
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (do_push) begin
      ptr <= ptr + PW'(1);
      if (!full) count <= count + CW'(1);
    end else if (do_pop) begin
      ptr   <= ptr - PW'(1);
      count <= count - CW'(1);
    end
  end

  // entry storage carries no reset; count alone decides validity
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= push_data;
  end

endmodule

// File: rtl/pc_gen.sv
// Fetch PC generator: priority select of trap / redirect / return / jump / sequential,
// with a return-address stack for call/return prediction.
module pc_gen
  import pc_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int unsigned     INC          = PC_INC_DEFAULT,
  parameter int              RAS_DEPTH    = 4
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_stall,
  input  logic            i_trap_valid,
  input  logic [XLEN-1:0] i_trap_pc,
  input  logic            i_redirect_valid,
  input  logic [XLEN-1:0] i_redirect_pc,
  input  logic            i_jump_valid,
  input  logic [XLEN-1:0] i_jump_pc,
  input  logic            i_call_valid,
  input  logic [XLEN-1:0] i_call_ret_addr,
  input  logic            i_ret_valid,
  output logic [XLEN-1:0] o_pc,
  output pc_src_e         o_pc_src,
  output logic            o_ras_miss,
  output logic            o_ras_empty,
  output logic            o_ras_full
);

  logic            flush;
  logic            accept;
  logic            call_acc;
  logic            ret_acc;
  logic [XLEN-1:0] ras_top;
  logic            ras_empty;
  logic            ras_full;
  logic [XLEN-1:0] next_pc;
  pc_src_e         next_src;

  function automatic logic [XLEN-1:0] align(input logic [XLEN-1:0] a);
    return a & ~XLEN'(3);
  endfunction

  assign flush    = i_trap_valid || i_redirect_valid;
  assign accept   = !i_stall && !flush;
  assign call_acc = accept && i_call_valid;
  assign ret_acc  = accept && i_ret_valid;

  pc_ras #(
    .XLEN      (XLEN),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (i_clk),
    .reset     (i_reset),
    .push      (call_acc),
    .pop       (ret_acc),
    .clear     (flush),
    .push_data (i_call_ret_addr),
    .top       (ras_top),
    .empty     (ras_empty),
    .full      (ras_full)
  );

  always_comb begin
    next_pc  = o_pc + XLEN'(INC);
    next_src = PC_SRC_SEQ;
    if (i_trap_valid) begin
      next_pc  = align(i_trap_pc);
      next_src = PC_SRC_TRAP;
    end else if (i_redirect_valid) begin
      next_pc  = align(i_redirect_pc);
      next_src = PC_SRC_REDIRECT;
    end else if (ret_acc && !ras_empty) begin
      next_pc  = align(ras_top);
      next_src = PC_SRC_RAS;
    end else if (i_jump_valid) begin
      next_pc  = align(i_jump_pc);
      next_src = PC_SRC_JUMP;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_pc       <= RESET_VECTOR;
      o_pc_src   <= PC_SRC_RESET;
      o_ras_miss <= 1'b0;
    end else begin
      o_ras_miss <= ret_acc && ras_empty;
      if (flush || !i_stall) begin
        o_pc     <= next_pc;
        o_pc_src <= next_src;
      end
    end
  end

  assign o_ras_empty = ras_empty;
  assign o_ras_full  = ras_full;

endmodule

// File: tb/tb_pc_gen.sv
// Bench for pc_gen: directed vector table, reset-override sequence, then random
// stimulus against a queue-based reference model.
module tb_pc_gen;
  import pc_pkg::*;

  localparam logic [31:0] RV    = 32'h100;
  localparam int          DEPTH = 4;

  logic        i_clk, i_reset, i_stall;
  logic        i_trap_valid, i_redirect_valid, i_jump_valid, i_call_valid, i_ret_valid;
  logic [31:0] i_trap_pc, i_redirect_pc, i_jump_pc, i_call_ret_addr;
  logic [31:0] o_pc;
  pc_src_e     o_pc_src;
  logic        o_ras_miss, o_ras_empty, o_ras_full;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [5:0]  ctl;  // {stall, trap, redirect, jump, call, ret}
    logic [31:0] trap_pc, redir_pc, jump_pc, call_addr;
    logic [31:0] pc;
    pc_src_e     src;
    logic [2:0]  flags; // {miss, empty, full}
  } vec_t;

  vec_t tbl[$];

  logic [31:0] m_pc;
  pc_src_e     m_src;
  logic        m_miss;
  logic [31:0] m_q[$];

  pc_gen #(
    .XLEN         (32),
    .RESET_VECTOR (RV),
    .INC          (4),
    .RAS_DEPTH    (DEPTH)
  ) dut (
    .i_clk            (i_clk),
    .i_reset          (i_reset),
    .i_stall          (i_stall),
    .i_trap_valid     (i_trap_valid),
    .i_trap_pc        (i_trap_pc),
    .i_redirect_valid (i_redirect_valid),
    .i_redirect_pc    (i_redirect_pc),
    .i_jump_valid     (i_jump_valid),
    .i_jump_pc        (i_jump_pc),
    .i_call_valid     (i_call_valid),
    .i_call_ret_addr  (i_call_ret_addr),
    .i_ret_valid      (i_ret_valid),
    .o_pc             (o_pc),
    .o_pc_src         (o_pc_src),
    .o_ras_miss       (o_ras_miss),
    .o_ras_empty      (o_ras_empty),
    .o_ras_full       (o_ras_full)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  function automatic vec_t v(input logic [5:0] ctl, input logic [31:0] tpc, input logic [31:0] rpc,
                             input logic [31:0] jpc, input logic [31:0] cpc, input logic [31:0] epc,
                             input pc_src_e esrc, input logic [2:0] flags);
    vec_t r;
    r.ctl = ctl; r.trap_pc = tpc; r.redir_pc = rpc; r.jump_pc = jpc; r.call_addr = cpc;
    r.pc = epc; r.src = esrc; r.flags = flags;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string name, input logic [31:0] pc, input pc_src_e src,
                           input logic miss, input logic empty, input logic full);
    chk({name, ".pc"},    o_pc, pc);
    chk({name, ".src"},   32'(o_pc_src), 32'(src));
    chk({name, ".miss"},  32'(o_ras_miss), 32'(miss));
    chk({name, ".empty"}, 32'(o_ras_empty), 32'(empty));
    chk({name, ".full"},  32'(o_ras_full), 32'(full));
  endtask

  task automatic clear_inputs();
    i_stall = 1'b0; i_trap_valid = 1'b0; i_redirect_valid = 1'b0;
    i_jump_valid = 1'b0; i_call_valid = 1'b0; i_ret_valid = 1'b0;
    i_trap_pc = '0; i_redirect_pc = '0; i_jump_pc = '0; i_call_ret_addr = '0;
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // Reference: stack as a queue, newest at the back; spec rules applied directly.
  task automatic model_update();
    logic [31:0] npc;
    pc_src_e     nsrc;
    npc = m_pc; nsrc = m_src; m_miss = 1'b0;
    if (i_trap_valid) begin
      npc = i_trap_pc & ~32'd3; nsrc = PC_SRC_TRAP; m_q.delete();
    end else if (i_redirect_valid) begin
      npc = i_redirect_pc & ~32'd3; nsrc = PC_SRC_REDIRECT; m_q.delete();
    end else if (!i_stall) begin
      if (i_ret_valid && m_q.size() > 0) begin
        npc = m_q[$] & ~32'd3; nsrc = PC_SRC_RAS;
        if (i_call_valid) m_q[$] = i_call_ret_addr;
        else void'(m_q.pop_back());
      end else begin
        m_miss = i_ret_valid;
        if (i_jump_valid) begin
          npc = i_jump_pc & ~32'd3; nsrc = PC_SRC_JUMP;
        end else begin
          npc = m_pc + 32'd4; nsrc = PC_SRC_SEQ;
        end
        if (i_call_valid) begin
          m_q.push_back(i_call_ret_addr);
          if (m_q.size() > DEPTH) void'(m_q.pop_front());
        end
      end
    end
    m_pc = npc; m_src = nsrc;
  endtask

  initial begin
    clear_inputs();
    i_reset = 1'b1;
    repeat (2) @(posedge i_clk);
    #1;
    check_all("reset", RV, PC_SRC_RESET, 1'b0, 1'b1, 1'b0);
    i_reset = 1'b0;

    //                 ctl        trap      redir     jump          call      exp_pc        src              {miss,empty,full}
    tbl.push_back(v(6'b000000, 0,        0,        0,            0,        32'h104,      PC_SRC_SEQ,      3'b010));
    tbl.push_back(v(6'b000000, 0,        0,        0,            0,        32'h108,      PC_SRC_SEQ,      3'b010));
    tbl.push_back(v(6'b000000, 0,        0,        0,            0,        32'h10C,      PC_SRC_SEQ,      3'b010));
    tbl.push_back(v(6'b000100, 0,        0,        32'h200,      0,        32'h200,      PC_SRC_JUMP,     3'b010));
    tbl.push_back(v(6'b100000, 0,        0,        0,            0,        32'h200,      PC_SRC_JUMP,     3'b010));
    tbl.push_back(v(6'b100100, 0,        0,        32'h300,      0,        32'h200,      PC_SRC_JUMP,     3'b010));
    tbl.push_back(v(6'b101000, 0,        32'h400,  0,            0,        32'h400,      PC_SRC_REDIRECT, 3'b010));
    tbl.push_back(v(6'b000100, 0,        0,        32'h123,      0,        32'h120,      PC_SRC_JUMP,     3'b010));
    tbl.push_back(v(6'b000010, 0,        0,        0,            32'h10,   32'h124,      PC_SRC_SEQ,      3'b000));
    tbl.push_back(v(6'b000010, 0,        0,        0,            32'h20,   32'h128,      PC_SRC_SEQ,      3'b000));
    tbl.push_back(v(6'b000010, 0,        0,        0,            32'h30,   32'h12C,      PC_SRC_SEQ,      3'b000));
    tbl.push_back(v(6'b000010, 0,        0,        0,            32'h40,   32'h130,      PC_SRC_SEQ,      3'b001));
    tbl.push_back(v(6'b000010, 0,        0,        0,            32'h50,   32'h134,      PC_SRC_SEQ,      3'b001));
    tbl.push_back(v(6'b000001, 0,        0,        0,            0,        32'h50,       PC_SRC_RAS,      3'b000));
    tbl.push_back(v(6'b000001, 0,        0,        0,            0,        32'h40,       PC_SRC_RAS,      3'b000));
    tbl.push_back(v(6'b000001, 0,        0,        0,            0,        32'h30,       PC_SRC_RAS,      3'b000));
    tbl.push_back(v(6'b000001, 0,        0,        0,            0,        32'h20,       PC_SRC_RAS,      3'b010));
    tbl.push_back(v(6'b000001, 0,        0,        0,            0,        32'h24,       PC_SRC_SEQ,      3'b110));
    tbl.push_back(v(6'b000000, 0,        0,        0,            0,        32'h28,       PC_SRC_SEQ,      3'b010));
    tbl.push_back(v(6'b000101, 0,        0,        32'h500,      0,        32'h500,      PC_SRC_JUMP,     3'b110));
    tbl.push_back(v(6'b000010, 0,        0,        0,            32'h33,   32'h504,      PC_SRC_SEQ,      3'b000));
    tbl.push_back(v(6'b000011, 0,        0,        0,            32'h77,   32'h30,       PC_SRC_RAS,      3'b000));
    tbl.push_back(v(6'b000001, 0,        0,        0,            0,        32'h74,       PC_SRC_RAS,      3'b010));
    tbl.push_back(v(6'b000011, 0,        0,        0,            32'h88,   32'h78,       PC_SRC_SEQ,      3'b100));
    tbl.push_back(v(6'b100010, 0,        0,        0,            32'h90,   32'h78,       PC_SRC_SEQ,      3'b000));
    tbl.push_back(v(6'b011100, 32'h80,   32'h400,  32'h900,      0,        32'h80,       PC_SRC_TRAP,     3'b010));
    tbl.push_back(v(6'b000001, 0,        0,        0,            0,        32'h84,       PC_SRC_SEQ,      3'b110));
    tbl.push_back(v(6'b101000, 0,        32'h403,  0,            0,        32'h400,      PC_SRC_REDIRECT, 3'b010));
    tbl.push_back(v(6'b010000, 32'h1FF,  0,        0,            0,        32'h1FC,      PC_SRC_TRAP,     3'b010));
    tbl.push_back(v(6'b000100, 0,        0,        32'hFFFFFFFC, 0,        32'hFFFFFFFC, PC_SRC_JUMP,     3'b010));
    tbl.push_back(v(6'b000000, 0,        0,        0,            0,        32'h0,        PC_SRC_SEQ,      3'b010));
    tbl.push_back(v(6'b100001, 0,        0,        0,            0,        32'h0,        PC_SRC_SEQ,      3'b010));
    tbl.push_back(v(6'b000010, 0,        0,        0,            32'hA0,   32'h4,        PC_SRC_SEQ,      3'b000));
    tbl.push_back(v(6'b000101, 0,        0,        32'h600,      0,        32'hA0,       PC_SRC_RAS,      3'b010));

    for (int n = 0; n < tbl.size(); n++) begin
      {i_stall, i_trap_valid, i_redirect_valid, i_jump_valid, i_call_valid, i_ret_valid} = tbl[n].ctl;
      i_trap_pc       = tbl[n].trap_pc;
      i_redirect_pc   = tbl[n].redir_pc;
      i_jump_pc       = tbl[n].jump_pc;
      i_call_ret_addr = tbl[n].call_addr;
      step();
      check_all($sformatf("vec%0d", n), tbl[n].pc, tbl[n].src,
                tbl[n].flags[2], tbl[n].flags[1], tbl[n].flags[0]);
    end

    // Reset arriving mid-cycle while stalled and redirecting must win immediately.
    clear_inputs();
    i_call_valid = 1'b1; i_call_ret_addr = 32'h44;
    step();
    i_call_valid = 1'b0;
    i_stall = 1'b1; i_redirect_valid = 1'b1; i_redirect_pc = 32'h400;
    #3;
    i_reset = 1'b1;
    #1;
    check_all("async_reset", RV, PC_SRC_RESET, 1'b0, 1'b1, 1'b0);
    step();
    clear_inputs();
    i_reset = 1'b0;
    check_all("reset_hold", RV, PC_SRC_RESET, 1'b0, 1'b1, 1'b0);
    step();
    check_all("post_reset", RV + 32'd4, PC_SRC_SEQ, 1'b0, 1'b1, 1'b0);

    m_pc = RV + 32'd4; m_src = PC_SRC_SEQ; m_miss = 1'b0; m_q.delete();
    for (int n = 0; n < 500; n++) begin
      i_stall          = ($urandom_range(0, 3) == 0);
      i_trap_valid     = ($urandom_range(0, 24) == 0);
      i_redirect_valid = ($urandom_range(0, 14) == 0);
      i_jump_valid     = ($urandom_range(0, 4) == 0);
      i_call_valid     = ($urandom_range(0, 2) == 0);
      i_ret_valid      = ($urandom_range(0, 2) == 0);
      i_trap_pc        = $urandom();
      i_redirect_pc    = $urandom();
      i_jump_pc        = $urandom();
      i_call_ret_addr  = $urandom();
      model_update();
      step();
      check_all($sformatf("rand%0d", n), m_pc, m_src, m_miss,
                m_q.size() == 0, m_q.size() == DEPTH);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
